// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
// APB3 completer fronting a small word-addressed register file. Each transfer
// can be stretched by a fixed number of wait states. Accesses that are
// misaligned or fall outside the register file complete with pslverr and
// leave the registers untouched. All bus outputs come straight from flops.
//
// Handshake: the requester presents a setup cycle (psel=1, penable=0) and then
// holds psel=1, penable=1 with stable paddr/pwrite/pwdata until it sees
// pready=1. The transfer completes in the cycle pready is high, and only in
// that cycle are prdata (for reads) and pslverr meaningful. Dropping psel
// before pready abandons the transfer with no side effects.
//
// o_dbg_state encoding: 0 = IDLE, 1 = WAIT, 2 = ACK.

module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclock,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [1:0]            o_dbg_state
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Counter preload: the first access cycle is already one of the wait states.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_setup;
  logic [ADDR_WIDTH-1:0] w_dec_addr;
  logic                  w_dec_write;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_ack_prdata;
  logic                  w_commit;

  assign w_setup = psel & ~penable;

  // In IDLE the decode looks at the live bus so a zero-wait transfer can
  // load its response on the setup edge; afterwards it uses the latched copy.
  assign w_dec_addr  = (r_state == S_IDLE) ? paddr  : r_addr;
  assign w_dec_write = (r_state == S_IDLE) ? pwrite : r_write;

  assign w_idx = w_dec_addr[2 +: IDX_W];
  assign w_err = (w_dec_addr[1:0] != 2'b00) ||
                 ((w_dec_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH));

  // Read data returned on entering ACK; writes and errors return zero.
  assign w_ack_prdata = (w_dec_write || w_err) ? '0 : r_mem[w_idx];

  // A good write commits on the edge that closes its ACK cycle.
  assign w_commit = (r_state == S_ACK) && r_write && !w_err;

  assign prdata      = r_prdata;
  assign pready      = r_pready;
  assign pslverr     = r_pslverr;
  assign o_dbg_state = r_state;

  // Transfer sequencer: setup capture, wait-state count, one-cycle response.
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_IDLE: begin
          // psel with penable already high is not a valid setup; ignore it.
          if (w_setup) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            if (WAIT_CYCLES == 0) begin
              r_state   <= S_ACK;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_ack_prdata;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd0) begin
            r_state   <= S_ACK;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= w_ack_prdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register file storage; cleared by reset, written only by a good write.
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one zero-wait and one three-wait instance,
// each on its own bus, checked against a word-array reference model.
module tb_apb_slave_regfile;

  localparam int W0 = 0;
  localparam int W1 = 3;

  // ---------------- clock / reset ----------------
  logic        pclock;
  logic        presetn [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [1:0]  dbg     [2];
  int          cyc;

  initial begin
    pclock = 1'b0;
    forever #5 pclock = ~pclock;
  end

  always @(posedge pclock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  apb_slave_regfile #(.WAIT_CYCLES(W0)) u_dut0 (
    .pclock(pclock), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .o_dbg_state(dbg[0])
  );

  apb_slave_regfile #(.WAIT_CYCLES(W1)) u_dut1 (
    .pclock(pclock), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .o_dbg_state(dbg[1])
  );

  // ---------------- scoreboard ----------------
  int          n_pass;
  int          n_total;
  logic [31:0] exp_q [$];
  logic [31:0] m_mem [2][16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference rules: word stride 4, 16 words, anything else is an error.
  function automatic bit m_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 16);
  endfunction

  task automatic model_apply(input int d, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] e_rd,
                             output bit e_err);
    e_err = m_err(a);
    e_rd  = 32'h0;
    if (!e_err) begin
      if (wr) m_mem[d][a / 4] = wd;
      else    e_rd = m_mem[d][a / 4];
    end
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < 16; i++) m_mem[d][i] = 32'h0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the ACK cycle, so a
  // following call drives the next setup with no idle cycle in between.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int acc);
    bit done;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge pclock); #1;
    penable[d] = 1'b1;
    acc = 0; done = 1'b0; rd = 32'h0; err = 1'b0;
    while (!done) begin
      @(negedge pclock);
      acc++;
      if (pready[d]) begin
        rd = prdata[d]; err = pslverr[d]; done = 1'b1;
      end else begin
        check("wait_prdata_zero", prdata[d], 32'h0);
        check("wait_pslverr_zero", {31'b0, pslverr[d]}, 32'h0);
        if (acc > 40) begin
          check("pready_timeout", 32'h0, 32'h1);
          done = 1'b1;
        end
      end
      @(posedge pclock); #1;
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclock);
    #1;
  endtask

  // Run one transfer and compare it against the model.
  task automatic model_xfer(input int d, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input string tag);
    logic [31:0] rd, e_rd;
    logic        err;
    bit          e_err;
    int          acc;
    model_apply(d, wr, a, wd, e_rd, e_err);
    xfer(d, wr, a, wd, rd, err, acc);
    check({tag, "_pslverr"}, {31'b0, err}, {31'b0, e_err});
    if (!wr) check({tag, "_prdata"}, rd, e_rd);
    check({tag, "_latency"}, acc, (d == 0) ? W0 + 1 : W1 + 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd, e_rd, a, wd;
    logic        err;
    bit          e_err, wr;
    int          acc, t0, seen;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_003C, 32'h1234_5678, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0006, 32'hAAAA_AAAA, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_003C, 32'h0,         32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0002, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'hFFFF_FFF0, 32'h5555_5555, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h0000_0030, 32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};

    n_pass = 0; n_total = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      presetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = 32'h0; pwdata[d] = 32'h0;
      model_clear(d);
    end
    repeat (3) @(negedge pclock);
    for (int d = 0; d < 2; d++) begin
      check("reset_pready", {31'b0, pready[d]}, 32'h0);
      check("reset_pslverr", {31'b0, pslverr[d]}, 32'h0);
      check("reset_prdata", prdata[d], 32'h0);
      check("reset_state", {30'b0, dbg[d]}, 32'h0);
      presetn[d] = 1'b1;
    end
    idle(1);

    // Zero-wait directed table, including error and aliasing cases.
    for (int i = 0; i < 12; i++) begin
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, acc);
      model_apply(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e_rd, e_err);
      check($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      if (!vecs[i].wr) check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_latency", i), acc, 1);
      if (i % 3 == 2) idle(1);
    end

    // Three-wait read of 0x08: pready on the 4th access cycle.
    model_xfer(1, 1'b1, 32'h08, 32'h0BAD_F00D, "w3_wr08");
    xfer(1, 1'b0, 32'h08, 32'h0, rd, err, acc);
    check("w3_rd08_latency", acc, 4);
    check("w3_rd08_prdata", rd, 32'h0BAD_F00D);
    check("w3_rd08_pslverr", {31'b0, err}, 32'h0);

    // Setup-less access phase in IDLE is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h0; pwdata[0] = 32'h7777_7777;
    seen = 0;
    repeat (4) begin @(negedge pclock); if (pready[0]) seen++; end
    check("protocol_violation_no_pready", seen, 0);
    @(posedge pclock); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    model_xfer(0, 1'b0, 32'h0, 32'h0, "after_violation_rd00");

    // Reset during WAIT clears everything.
    model_xfer(1, 1'b1, 32'h00, 32'hCAFE_F00D, "pre_rst_wr00");
    model_xfer(1, 1'b0, 32'h00, 32'h0, "pre_rst_rd00");
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0C; pwdata[1] = 32'h9999_9999;
    @(posedge pclock); #1; penable[1] = 1'b1;
    @(posedge pclock); #1;
    presetn[1] = 1'b0;
    #1;
    check("midrst_pready", {31'b0, pready[1]}, 32'h0);
    check("midrst_pslverr", {31'b0, pslverr[1]}, 32'h0);
    check("midrst_prdata", prdata[1], 32'h0);
    check("midrst_state", {30'b0, dbg[1]}, 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge pclock); presetn[1] = 1'b1;
    model_clear(1);
    idle(1);
    model_xfer(1, 1'b0, 32'h00, 32'h0, "post_rst_rd00");
    model_xfer(1, 1'b0, 32'h0C, 32'h0, "post_rst_rd0c");

    // Abort by dropping psel during WAIT on a write to 0x10.
    model_xfer(1, 1'b1, 32'h10, 32'h1111_1111, "abort_pre_wr10");
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'h2222_2222;
    @(posedge pclock); #1; penable[1] = 1'b1;
    @(posedge pclock); #1; psel[1] = 1'b0; penable[1] = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge pclock); if (pready[1]) seen++; end
    check("abort_no_pready", seen, 0);
    check("abort_state_idle", {30'b0, dbg[1]}, 32'h0);
    @(posedge pclock); #1;
    model_xfer(1, 1'b0, 32'h10, 32'h0, "abort_rd10");

    // Back-to-back sweep on both instances: no bubble between transfers.
    for (int d = 0; d < 2; d++) begin
      t0 = cyc;
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        exp_q.push_back(wd);
        xfer(d, 1'b1, 32'(i * 4), wd, rd, err, acc);
        model_apply(d, 1'b1, 32'(i * 4), wd, e_rd, e_err);
      end
      for (int i = 0; i < 16; i++) begin
        xfer(d, 1'b0, 32'(i * 4), 32'h0, rd, err, acc);
        check($sformatf("b2b_d%0d_rd%0d", d, i), rd, exp_q.pop_front());
        check($sformatf("b2b_d%0d_err%0d", d, i), {31'b0, err}, 32'h0);
      end
      check($sformatf("b2b_d%0d_cycles", d), cyc - t0, 32 * (((d == 0) ? W0 : W1) + 2));
      idle(2);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 15) * 4);
          7:                   a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
          8:                   a = 32'h40 + 32'($urandom_range(0, 255) * 4);
          default:             a = $urandom;
        endcase
        wr = ($urandom_range(0, 1) == 1);
        wd = $urandom;
        model_xfer(d, wr, a, wd, $sformatf("rand_d%0d", d));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
